// File: rtl/prog_loader.sv
// Streams a length-prefixed, big-endian program image into CPU memory over a byte link.
// Optional checksum trailer is compiled in with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_en,
  output logic [31:0] inst_addr,
  output logic [31:0] prog_instruction,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_FLUSH, S_DONE, S_ERROR
  } state_t;

  localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q;
  logic [23:0] shift_q;
  logic [15:0] len_q;
  logic [15:0] words_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
`endif

  logic        accept;
  logic        start_session;
  logic [31:0] word_full;
  logic [15:0] len_full;
  logic [15:0] words_inc;

  assign accept    = rx_valid && rx_ready;
  assign word_full = {shift_q, rx_data};
  assign len_full  = {shift_q[7:0], rx_data};
  assign words_inc = words_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    start_session = 1'b0;
    rx_ready      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    prog_en       = 1'b1;
    case (state_q)
      S_IDLE: begin
        start_session = start;
      end
      S_LEN: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept && byte_cnt_q == 2'd1) begin
          if (len_full == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_FLUSH;
`endif
          end else if ({16'd0, len_full} > MAX_W32) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept && byte_cnt_q == 2'd3 && words_inc == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_FLUSH;
`endif
        end
      end
      S_CSUM: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept && byte_cnt_q == 2'd3)
          state_d = (word_full == csum_q) ? S_FLUSH : S_ERROR;
`else
        state_d = S_IDLE;
`endif
      end
      S_FLUSH: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        prog_en       = 1'b0;
        done          = 1'b1;
        start_session = start;
      end
      S_ERROR: begin
        error         = 1'b1;
        start_session = start;
      end
      default: state_d = S_IDLE;
    endcase
    if (start_session)
      state_d = S_LEN;
  end

  // ---- registered state and datapath ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      len_q      <= 16'd0;
      words_q    <= 16'd0;
      addr_q     <= BASE_ADDR;
      instr_q    <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      if (start_session) begin
        byte_cnt_q <= 2'd0;
        shift_q    <= 24'd0;
        words_q    <= 16'd0;
        addr_q     <= BASE_ADDR;
        instr_q    <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_q     <= 32'd0;
`endif
      end else if (accept) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        shift_q    <= {shift_q[15:0], rx_data};
        if (state_q == S_LEN && byte_cnt_q == 2'd1) begin
          len_q      <= len_full;
          byte_cnt_q <= 2'd0;
        end
        // Word index k equals the count before increment, so the address is BASE + 4k.
        if (state_q == S_DATA && byte_cnt_q == 2'd3) begin
          instr_q <= word_full;
          addr_q  <= BASE_ADDR + {14'd0, words_q, 2'b00};
          words_q <= words_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_q  <= csum_q + word_full;
`endif
        end
      end
    end
  end

  assign inst_addr        = addr_q;
  assign prog_instruction = instr_q;
  assign words_loaded     = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: scoreboarded memory writes plus release/error/reset checks.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, prog_en, busy, done, error;
  logic [31:0] inst_addr, prog_instruction;
  logic [15:0] words_loaded;

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .prog_en(prog_en), .inst_addr(inst_addr),
    .prog_instruction(prog_instruction), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          ready_drop = 1'b0;
  logic [15:0] wl_prev = 16'd0;
  logic [7:0]  img[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // CPU memory model: writes on every edge while programming mode is held.
  always @(posedge clk) if (prog_en === 1'b1) mem[inst_addr] = prog_instruction;

  // Scoreboard: each new word reported by words_loaded pops one expected write.
  always @(negedge clk) begin
    if (words_loaded !== wl_prev) begin
      if (words_loaded != 16'd0) begin
        if (exp_q.size() == 0) begin
          check("sb_pending", 32'(exp_q.size()), 32'd1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", inst_addr, e.addr);
          check("wr_data", prog_instruction, e.data);
        end
      end
      wl_prev = words_loaded;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
      if (rx_ready !== 1'b1) ready_drop = 1'b1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (rx_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("byte_accept", {31'd0, rx_ready}, 32'd1);
    if (rx_ready === 1'b1) begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_img(input int gap);
    foreach (img[i]) send_byte(img[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_release(input logic [15:0] wl);
    check("flush_prog_en", {31'd0, prog_en}, 32'd1);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_rx_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    check("rel_done", {31'd0, done}, 32'd1);
    check("rel_prog_en", {31'd0, prog_en}, 32'd0);
    check("rel_busy", {31'd0, busy}, 32'd0);
    check("rel_words", {16'd0, words_loaded}, {16'd0, wl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_prog_en", {31'd0, prog_en}, 32'd1);
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_instr", prog_instruction, 32'h0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic two-word image
    pulse_start();
    check("len_busy", {31'd0, busy}, 32'd1);
    check("len_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("len_instr_nop", prog_instruction, 32'h0);
    exp_q.push_back('{32'h0, 32'h2008_0005});
    exp_q.push_back('{32'h4, 32'h0000_000C});
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
`ifdef PROG_LOADER_CHECKSUM_EN
    img.push_back(8'h20); img.push_back(8'h08); img.push_back(8'h00); img.push_back(8'h11);
`endif
    send_img(0);
    check_release(16'd2);
    check("mem0", mem[32'h0], 32'h2008_0005);
    check("mem4", mem[32'h4], 32'h0000_000C);

    // Same image with rx_valid toggling
    pulse_start();
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_words", {16'd0, words_loaded}, 32'd0);
    ready_drop = 1'b0;
    exp_q.push_back('{32'h0, 32'h2008_0005});
    exp_q.push_back('{32'h4, 32'h0000_000C});
    send_img(1);
    check_release(16'd2);
    check("gap_ready_drop", {31'd0, ready_drop}, 32'd0);
    check("gap_mem0", mem[32'h0], 32'h2008_0005);
    check("gap_mem4", mem[32'h4], 32'h0000_000C);

    // Over-length image
    pulse_start();
    img = '{8'h04, 8'h01};
    send_img(0);
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_words", {16'd0, words_loaded}, 32'd0);
    check("ovf_prog_en", {31'd0, prog_en}, 32'd1);
    rx_data = 8'hAA; rx_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("ovf_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("ovf_words_hold", {16'd0, words_loaded}, 32'd0);
    check("ovf_error_hold", {31'd0, error}, 32'd1);
    rx_valid = 1'b0;

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum, then recovery
    pulse_start();
    check("csum_err_cleared", {31'd0, error}, 32'd0);
    exp_q.push_back('{32'h0, 32'h2008_0005});
    exp_q.push_back('{32'h4, 32'h0000_000C});
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C,
            8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_img(0);
    check("csum_error", {31'd0, error}, 32'd1);
    check("csum_done", {31'd0, done}, 32'd0);
    check("csum_prog_en", {31'd0, prog_en}, 32'd1);
    check("csum_words", {16'd0, words_loaded}, 32'd2);
    pulse_start();
    exp_q.push_back('{32'h0, 32'h2008_0005});
    exp_q.push_back('{32'h4, 32'h0000_000C});
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C,
            8'h20, 8'h08, 8'h00, 8'h11};
    send_img(0);
    check_release(16'd2);
`endif

    // Reset in the middle of word 0
    pulse_start();
    img = '{8'h00, 8'h02, 8'h20, 8'h08};
    send_img(0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_prog_en", {31'd0, prog_en}, 32'd1);
    check("mid_inst_addr", inst_addr, 32'h0);
    check("mid_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("mid_words", {16'd0, words_loaded}, 32'd0);
    @(posedge clk); #1;
    pulse_start();
    exp_q.push_back('{32'h0, 32'hDEAD_BEEF});
    img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef PROG_LOADER_CHECKSUM_EN
    img.push_back(8'hDE); img.push_back(8'hAD); img.push_back(8'hBE); img.push_back(8'hEF);
`endif
    send_img(0);
    check_release(16'd1);
    check("mid_mem0", mem[32'h0], 32'hDEAD_BEEF);

    // Empty image
    pulse_start();
    img = '{8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h00);
`endif
    send_img(0);
    check_release(16'd0);
    check("empty_inst_addr", inst_addr, 32'h0);
    check("empty_instr", prog_instruction, 32'h0);
    pulse_start();
    check("empty_restart_done", {31'd0, done}, 32'd0);
    check("empty_restart_busy", {31'd0, busy}, 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
